// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM data-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;

    localparam int MEM_RD_LAT = 1;
    localparam int MAX_CH     = 8;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int CH_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of per-channel request signals and the RAM data port seen by the arbiter.
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        we;
    logic [NUM_CH-1:0]        lock;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        ack;
    logic [NUM_CH-1:0]        gnt;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_we;
    logic                     mem_re;
    logic [DATA_W-1:0]        mem_rdata;

    // Master side is the environment: requestors plus the RAM itself.
    modport master (
        output req, we, lock, addr, wdata, mem_rdata,
        input  ack, gnt, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata,
        output ack, gnt, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0,
// isolate the lowest set bit, then rotate the one-hot back.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int IW     = 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] winner_o,
    output logic              valid_o
);
    logic [2*NUM_CH-1:0] reqDbl;
    logic [NUM_CH-1:0]   reqRot;
    logic [NUM_CH-1:0]   pickRot;
    logic [2*NUM_CH-1:0] pickDbl;

    assign reqDbl  = {req_i, req_i} >> ptr_i;
    assign reqRot  = reqDbl[NUM_CH-1:0];
    assign pickRot = reqRot & (~reqRot + NUM_CH'(1));
    assign pickDbl = {pickRot, pickRot} << ptr_i;

    assign winner_o = pickDbl[2*NUM_CH-1:NUM_CH];
    assign valid_o  = |req_i;
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the RAM data port between NUM_CH masters.
// Define MEM_ARB_LOCK_EN to let a channel hold the grant across transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          nrst,
    mem_arbiter_if.slave bus
);
    localparam int IW = CH_IDX_W(NUM_CH);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     winIdx_q, winIdx_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              isWrite_q, isWrite_d;
    logic              memWe_q, memWe_d;
    logic              memRe_q, memRe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_CH-1:0] pickReq;
    logic [NUM_CH-1:0] pick;
    logic              pickValid;
    logic [IW-1:0]     pickIdx;

`ifdef MEM_ARB_LOCK_EN
    logic              locked_q, locked_d;
    logic              lockHit;
    logic [NUM_CH-1:0] winMask;

    // A live lock narrows the next arbitration to the previous winner alone.
    assign winMask = NUM_CH'(1) << winIdx_q;
    assign lockHit = locked_q && bus.req[winIdx_q];
    assign pickReq = lockHit ? winMask : bus.req;
`else
    logic unusedLock;

    assign unusedLock = ^bus.lock;
    assign pickReq    = bus.req;
`endif

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) uPicker (
        .req_i    (pickReq),
        .ptr_i    (ptr_q),
        .winner_o (pick),
        .valid_o  (pickValid)
    );

    always_comb begin
        pickIdx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick[k]) pickIdx = IW'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winIdx_d   = winIdx_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        isWrite_d  = isWrite_q;
        memWe_d    = 1'b0;
        memRe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_LOCK_EN
        locked_d   = locked_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                locked_d = 1'b0;
`endif
                if (pickValid) begin
                    winIdx_d   = pickIdx;
                    gnt_d      = pick;
                    isWrite_d  = bus.we[pickIdx];
                    memWe_d    = bus.we[pickIdx];
                    memRe_d    = !bus.we[pickIdx];
                    memAddr_d  = bus.addr[pickIdx*ADDR_W +: ADDR_W];
                    memWdata_d = bus.wdata[pickIdx*DATA_W +: DATA_W];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ack_d   = gnt_q;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!isWrite_q) rdata_d = bus.mem_rdata;
                gnt_d   = '0;
                ptr_d   = (winIdx_q == IW'(NUM_CH - 1)) ? '0 : winIdx_q + IW'(1);
`ifdef MEM_ARB_LOCK_EN
                locked_d = bus.lock[winIdx_q];
                if (bus.lock[winIdx_q]) ptr_d = ptr_q;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            winIdx_q   <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            isWrite_q  <= 1'b0;
            memWe_q    <= 1'b0;
            memRe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            rdata_q    <= '0;
`ifdef MEM_ARB_LOCK_EN
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winIdx_q   <= winIdx_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            isWrite_q  <= isWrite_d;
            memWe_q    <= memWe_d;
            memRe_q    <= memRe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_LOCK_EN
            locked_q   <= locked_d;
`endif
        end
    end

    // The RAM word arrives during RESP, so the acked read forwards it directly.
    assign bus.rdata     = (state_q == ST_RESP && !isWrite_q) ? bus.mem_rdata : rdata_q;
    assign bus.ack       = ack_q;
    assign bus.gnt       = gnt_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_re    = memRe_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter that shares the single data port of the unified instruction/data RAM between several masters (CPU load/store path, FPGA keypad/LCD loader, future DMA). It replaces the per-signal enable muxes that hard-select FPGA or CPU. It adds round-robin fairness, a per-channel request/acknowledge handshake and optional locked bursts. It sits between the masters and the RAM data port; the instruction port is not arbitrated.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel 0 has first pick after reset
- ADDR_W, 12, word address width to RAM
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge
- nrst  in  1  reset, synchronous, active-low
- req  in  NUM_CH  per-channel request level; held high until ack
- we  in  NUM_CH  per-channel write (1) / read (0) select
- lock  in  NUM_CH  per-channel hold-grant request; active only with MEM_ARB_LOCK_EN
- addr  in  NUM_CH*ADDR_W  packed per-channel address; channel i occupies [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_CH*DATA_W  packed per-channel write data
- ack  out  NUM_CH  one-hot, single-cycle completion pulse
- gnt  out  NUM_CH  one-hot, high while a channel owns the port
- rdata  out  DATA_W  read data, broadcast to all channels, valid only with ack
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_we  out  1  RAM write strobe
- mem_re  out  1  RAM read strobe
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_re

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, choose a winner. Register the winner's we/addr/wdata, set gnt, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive mem_addr/mem_wdata from the captured values. Pulse mem_we or mem_re for exactly this cycle. Go to RESP.
- RESP: capture mem_rdata into rdata (reads only; rdata holds its value on writes). Pulse ack[winner] and go to IDLE. gnt drops on entry to IDLE.
- Round-robin: search starts at ptr, wrapping modulo NUM_CH. After each grant, ptr = winner+1, wrapping from NUM_CH-1 to 0.
- req is sampled only in IDLE. Changes to req/addr/wdata during ISSUE or RESP are ignored.
- Requests from non-granted channels wait with no timeout. Their payload must stay stable.
- Requestor contract: after seeing ack, drop req or present a new transaction in the next cycle.
- Reset values:
  - state = IDLE, ptr = 0
  - ack, gnt, mem_we, mem_re = 0
  - mem_addr, mem_wdata, rdata = 0
- Reset mid-transaction aborts it. No ack is issued. A write already strobed in ISSUE is not undone.

## Timing
- Request sampled at cycle N (IDLE). mem strobe at N+1. ack plus rdata at N+2. Earliest next grant is sampled at N+3.
- Maximum throughput is one transaction per 3 cycles.
- Worst-case wait with no locks: (NUM_CH-1)*3 cycles after the current transaction ends.
- Simultaneous requests are resolved by ptr only. Channel index matters only for ties starting at ptr.
- At most one ack per cycle. ack never coincides with a mem strobe.

## Configuration
- MEM_ARB_LOCK_EN defined:
  - If lock[winner] is high in RESP, the next IDLE considers only that channel. ptr is not advanced.
  - Lock releases when lock drops, or when the locked channel's req is low in IDLE. Normal round-robin then resumes.
- MEM_ARB_LOCK_EN undefined: the lock input is ignored and arbitration is pure round-robin.

## Structure
- Package mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, RESP}
  - constants MEM_RD_LAT = 1 and MAX_CH = 8
  - function clog2-based CH_IDX_W
- Sub-module rr_picker: combinational rotate/priority-find/unrotate over NUM_CH. Inputs are req and ptr; outputs are a one-hot winner and a valid flag.

## Test plan
- Single read: ch0 req, we=0, addr=0x010, RAM word 0xDEADBEEF -> mem_re at N+1 with mem_addr=0x010; ack[0] and rdata=0xDEADBEEF at N+2.
- Single write then read-back: ch1 writes 0x12345678 to 0x3FF -> mem_we one cycle at N+1. A subsequent ch1 read returns 0x12345678.
- Contention: ch0 and ch1 req together continuously from reset -> grant order 0,1,0,1; acks 3 cycles apart, each followed by IDLE.
- Wrap with NUM_CH=4, all channels requesting, ptr=3 -> order 3,0,1,2.
- Lock (macro on): ch1 holds lock and req for 3 transactions while ch0 requests -> three ch1 acks before ch0 is granted. With the macro off, the order alternates.
- Reset asserted in ISSUE -> next cycle state=IDLE, all outputs 0, no ack ever issued for that transaction.
